reg_fifo: RTL

Synchronous first-word-fall-through FIFO that forms the reader end of the team's enabled-register write interface. A producer writes with `wr_en`/`wr_data` the same way it would load an enabled register. A consumer drains entries in order with `rd_en`. The block sits between datapath stages or between the CPU's MMIO port and a slower peripheral, and absorbs rate mismatch of up to `2**DEPTH_LOG2` words.

---
 rtl/reg_fifo.sv | 75 +++++++
 1 files changed

// File: rtl/reg_fifo.sv
// reg_fifo: synchronous first-word-fall-through FIFO.
// A producer pushes with wr_en/wr_data like loading an enabled register.
// A consumer pops the head word with rd_en.
// rd_data shows the head word combinationally whenever empty=0.
//
// Ports:
//   clk        sole clock, rising edge
//   rstn       synchronous active-low reset
//   wr_en      push request; wr_data is stored when accepted
//   wr_data    word to push
//   rd_en      pop request; the head word is removed when accepted
//   rd_data    head word, valid while empty=0
//   empty      no stored words
//   full       2**DEPTH_LOG2 stored words
//   count      stored word count, 0..2**DEPTH_LOG2
//   overflow   sticky: a write was rejected (cleared by reset only)
//   underflow  sticky: a read was rejected (cleared by reset only)
module reg_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int D = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]      mem [D];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic                  wa, ra;

  // A pop in the same cycle frees the slot, so a full FIFO still takes a write.
  // A write cannot satisfy a read while empty, because the word appears only after the edge.
  assign wa = wr_en & (~full | rd_en);
  assign ra = rd_en & ~empty;

  assign empty   = (count == '0);
  // count never exceeds D, so its MSB alone marks full.
  assign full    = count[DEPTH_LOG2];
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wp <= wp + PTR_ONE;
      if (ra) rp <= rp + PTR_ONE;
      if (wa && !ra)      count <= count + CNT_ONE;
      else if (ra && !wa) count <= count - CNT_ONE;
      if (wr_en && !wa) overflow  <= 1'b1;
      if (rd_en && !ra) underflow <= 1'b1;
    end
  end

  // Storage has no reset. Resetting the pointers already discards the stored words.
  always_ff @(posedge clk) begin
    if (rstn && wa) mem[wp] <= wr_data;
  end

endmodule
